// File: rtl/uart_cmd_dispatcher_pkg.sv
// rtl/uart_cmd_dispatcher_pkg.sv - command codes and FSM states for the UART command dispatcher
package dispatch_pkg;

    localparam logic [7:0] CMD_TG    = 8'hA0;
    localparam logic [7:0] CMD_SPI   = 8'hA1;
    localparam logic [7:0] CMD_IMG   = 8'hA2;
    localparam logic [7:0] NACK_CODE = 8'hEE;

    typedef enum logic [3:0] {
        IDLE,
        ARG0,
        ARG1,
        TG_WR,
        SPI_START,
        SPI_WAIT,
        IMG_REQ,
        IMG_WAIT,
        IMG_HI,
        IMG_LO,
        TX,
        NACK
    } state_t;

endpackage

// File: rtl/uart_cmd_dispatcher_if.sv
// rtl/uart_cmd_dispatcher_if.sv - UART, TG, SPI and image-buffer signals of the dispatcher
interface uart_cmd_dispatcher_if;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        tg_wr;
    logic [7:0]  tg_addr;
    logic [7:0]  tg_wdata;
    logic        spi_start;
    logic [7:0]  spi_tx;
    logic        spi_done;
    logic [7:0]  spi_rx;
    logic        img_rd;
    logic        img_valid;
    logic [15:0] img_data;
    logic        busy;
    logic        err;

    // Dispatcher side
    modport master (
        input  rx_valid, rx_data, tx_ready, spi_done, spi_rx, img_valid, img_data,
        output tx_valid, tx_data, tg_wr, tg_addr, tg_wdata, spi_start, spi_tx,
        output img_rd, busy, err
    );

    // Environment side (UART, TG, SPI master, image buffer)
    modport slave (
        output rx_valid, rx_data, tx_ready, spi_done, spi_rx, img_valid, img_data,
        input  tx_valid, tx_data, tg_wr, tg_addr, tg_wdata, spi_start, spi_tx,
        input  img_rd, busy, err
    );
endinterface

// File: rtl/uart_cmd_dispatcher_timeout.sv
// rtl/uart_cmd_dispatcher_timeout.sv - idle-cycle watchdog for payload and peripheral waits
module dispatch_timeout #(
    parameter int TIMEOUT = 400000,
    parameter int CNT_W   = 19
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);
    logic [CNT_W-1:0] cnt;

    assign expired = (cnt == CNT_W'(TIMEOUT));

    // Count enabled idle cycles, saturating at TIMEOUT until cleared
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en && !expired)
            cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/uart_cmd_dispatcher.sv
// rtl/uart_cmd_dispatcher.sv - host command parser and single-owner UART reply sequencer
import dispatch_pkg::*;

module uart_cmd_dispatcher #(
    parameter int TIMEOUT = 400000,
    parameter int CNT_W   = 19
) (
    input  logic           clk,
    input  logic           reset,
    uart_cmd_dispatcher_if.master bus
);
    state_t      state, state_n;
    logic [7:0]  cmd_q, tx_byte_q, tg_addr_q, tg_wdata_q, spi_tx_q;
    logic [15:0] pix_q;
    logic [8:0]  cnt_q;
    logic        err_q, err_n;
    logic        expired, tmo_clr, tmo_en;
    logic        tx_valid_w, tx_fire;

    assign tx_valid_w = (state == TX) || (state == NACK) || (state == IMG_HI) || (state == IMG_LO);
    assign tx_fire    = tx_valid_w && bus.tx_ready;

    // Watchdog only runs while waiting on the host or a peripheral
    assign tmo_en  = (state == ARG0) || (state == ARG1) || (state == SPI_WAIT) || (state == IMG_WAIT);
    assign tmo_clr = (state_n != state) || bus.rx_valid;

    dispatch_timeout #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clr     (tmo_clr),
        .en      (tmo_en),
        .expired (expired)
    );

    // Next-state and error decode; peripheral data beats a coincident timeout
    always_comb begin
        state_n = state;
        err_n   = 1'b0;
        case (state)
            IDLE: if (bus.rx_valid) begin
                if (bus.rx_data == CMD_TG || bus.rx_data == CMD_SPI || bus.rx_data == CMD_IMG)
                    state_n = ARG0;
                else begin
                    state_n = NACK;
                    err_n   = 1'b1;
                end
            end
            ARG0: if (bus.rx_valid) begin
                if (cmd_q == CMD_TG)       state_n = ARG1;
                else if (cmd_q == CMD_SPI) state_n = SPI_START;
                else                       state_n = IMG_REQ;
            end else if (expired) begin
                state_n = NACK;
                err_n   = 1'b1;
            end
            ARG1: if (bus.rx_valid) state_n = TG_WR;
                  else if (expired) begin state_n = NACK; err_n = 1'b1; end
            TG_WR:     state_n = TX;
            SPI_START: state_n = SPI_WAIT;
            SPI_WAIT: if (bus.spi_done) state_n = TX;
                      else if (expired) begin state_n = NACK; err_n = 1'b1; end
            IMG_REQ:   state_n = IMG_WAIT;
            IMG_WAIT: if (bus.img_valid) state_n = IMG_HI;
                      else if (expired) begin state_n = NACK; err_n = 1'b1; end
            IMG_HI: if (tx_fire) state_n = IMG_LO;
            IMG_LO: if (tx_fire) state_n = (cnt_q == 9'd1) ? IDLE : IMG_REQ;
            TX, NACK: if (tx_fire) state_n = IDLE;
            default: state_n = IDLE;
        endcase
        // Host bytes arriving while a command executes are discarded
        if (bus.rx_valid && state != IDLE && state != ARG0 && state != ARG1)
            err_n = 1'b1;
    end

    // State register plus all datapath latches
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            err_q      <= 1'b0;
            cmd_q      <= '0;
            tx_byte_q  <= '0;
            tg_addr_q  <= '0;
            tg_wdata_q <= '0;
            spi_tx_q   <= '0;
            pix_q      <= '0;
            cnt_q      <= '0;
        end else begin
            state <= state_n;
            err_q <= err_n;
            if (state == IDLE && bus.rx_valid)
                cmd_q <= bus.rx_data;
            if (state == ARG0 && bus.rx_valid) begin
                if (cmd_q == CMD_TG)       tg_addr_q <= bus.rx_data;
                else if (cmd_q == CMD_SPI) spi_tx_q  <= bus.rx_data;
                else                       cnt_q     <= (bus.rx_data == 8'd0) ? 9'd256 : {1'b0, bus.rx_data};
            end
            if (state == ARG1 && bus.rx_valid)
                tg_wdata_q <= bus.rx_data;
            if (state == TG_WR)
                tx_byte_q <= CMD_TG;
            if (state == SPI_WAIT && bus.spi_done)
                tx_byte_q <= bus.spi_rx;
            if (state == IMG_WAIT && bus.img_valid)
                pix_q <= bus.img_data;
            if (state == IMG_LO && tx_fire)
                cnt_q <= cnt_q - 9'd1;
            if (state_n == NACK && state != NACK)
                tx_byte_q <= NACK_CODE;
        end
    end

    assign bus.tx_valid  = tx_valid_w;
    assign bus.tx_data   = (state == IMG_HI) ? pix_q[15:8] :
                           (state == IMG_LO) ? pix_q[7:0]  : tx_byte_q;
    assign bus.tg_wr     = (state == TG_WR);
    assign bus.tg_addr   = tg_addr_q;
    assign bus.tg_wdata  = tg_wdata_q;
    assign bus.spi_start = (state == SPI_START);
    assign bus.spi_tx    = spi_tx_q;
    assign bus.img_rd    = (state == IMG_REQ);
    assign bus.busy      = (state != IDLE);
    assign bus.err       = err_q;
endmodule

// File: tb/tb_uart_cmd_dispatcher.sv
// tb/tb_uart_cmd_dispatcher.sv - scoreboard bench for uart_cmd_dispatcher
module tb_uart_cmd_dispatcher;
    localparam int TIMEOUT = 300;
    localparam int CNT_W   = 9;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    uart_cmd_dispatcher_if bus ();

    uart_cmd_dispatcher #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;
    logic [7:0]  exp_tx[$];
    logic [15:0] src_pix[$];
    int n_tg = 0, n_spi = 0, n_img = 0, n_err = 0, n_tx = 0;
    logic [7:0] exp_tg_addr, exp_tg_wdata, exp_spi_tx;
    logic       prev_hold = 1'b0;
    logic [7:0] prev_data = '0;
    logic       prev_err = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Monitor: sampled on the falling edge, away from the active edge
    always @(negedge clk) begin
        if (reset) begin
            prev_hold <= 1'b0;
            prev_err  <= 1'b0;
        end else begin
            if (prev_hold) begin
                chk("tx_hold_valid", {31'd0, bus.tx_valid}, 32'd1);
                chk("tx_hold_data", {24'd0, bus.tx_data}, {24'd0, prev_data});
            end
            if (prev_err)
                chk("err_width", {31'd0, bus.err}, 32'd0);
            if (bus.tx_valid && bus.tx_ready) begin
                n_tx++;
                if (exp_tx.size() == 0)
                    chk("tx_unexpected", {24'd0, bus.tx_data}, 32'hFFFF_FFFF);
                else
                    chk("tx_byte", {24'd0, bus.tx_data}, {24'd0, exp_tx.pop_front()});
            end
            if (bus.tg_wr) begin
                n_tg++;
                chk("tg_addr", {24'd0, bus.tg_addr}, {24'd0, exp_tg_addr});
                chk("tg_wdata", {24'd0, bus.tg_wdata}, {24'd0, exp_tg_wdata});
            end
            if (bus.spi_start) begin
                n_spi++;
                chk("spi_tx", {24'd0, bus.spi_tx}, {24'd0, exp_spi_tx});
            end
            if (bus.img_rd) n_img++;
            if (bus.err)    n_err++;
            prev_hold <= bus.tx_valid && !bus.tx_ready;
            prev_data <= bus.tx_data;
            prev_err  <= bus.err;
        end
    end

    // Image buffer model: answers each pop one cycle later from src_pix
    initial begin
        bus.img_valid = 1'b0;
        bus.img_data  = '0;
        forever begin
            @(negedge clk);
            if (bus.img_rd && !reset) begin
                @(posedge clk); #1;
                if (src_pix.size() == 0) begin
                    chk("img_underflow", 32'd1, 32'd0);
                end else begin
                    bus.img_valid = 1'b1;
                    bus.img_data  = src_pix.pop_front();
                    @(posedge clk); #1;
                    bus.img_valid = 1'b0;
                end
            end
        end
    end

    task automatic send(input logic [7:0] b);
        @(posedge clk); #1;
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
    endtask

    task automatic send_end();
        @(posedge clk); #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic push_pix(input logic [15:0] p);
        src_pix.push_back(p);
        exp_tx.push_back(p[15:8]);
        exp_tx.push_back(p[7:0]);
    endtask

    task automatic wait_idle(input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (!bus.busy && exp_tx.size() == 0) break;
        end
        if (i == budget) chk("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic spi_reply(input int delay, input logic [7:0] d);
        repeat (delay) @(posedge clk);
        #1;
        bus.spi_done = 1'b1;
        bus.spi_rx   = d;
        @(posedge clk); #1;
        bus.spi_done = 1'b0;
    endtask

    initial begin
        int e0, c0, t0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = '0;
        bus.tx_ready = 1'b1;
        bus.spi_done = 1'b0;
        bus.spi_rx   = '0;
        exp_tg_addr = '0; exp_tg_wdata = '0; exp_spi_tx = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_tx_valid", {31'd0, bus.tx_valid}, 32'd0);
        chk("rst_err", {31'd0, bus.err}, 32'd0);
        chk("rst_tg_wr", {31'd0, bus.tg_wr}, 32'd0);
        reset = 1'b0;

        // TG write
        exp_tg_addr = 8'h12; exp_tg_wdata = 8'h34; c0 = n_tg;
        exp_tx.push_back(8'hA0);
        send(8'hA0); send(8'h12); send(8'h34); send_end();
        chk("tg_wr_timing", {31'd0, bus.tg_wr}, 32'd1);
        wait_idle(50);
        chk("tg_wr_count", n_tg - c0, 1);

        // SPI exchange
        exp_spi_tx = 8'h5A; c0 = n_spi;
        exp_tx.push_back(8'hC3);
        send(8'hA1); send(8'h5A); send_end();
        chk("spi_start_timing", {31'd0, bus.spi_start}, 32'd1);
        chk("busy_spi", {31'd0, bus.busy}, 32'd1);
        spi_reply(100, 8'hC3);
        chk("spi_tx_valid_rise", {31'd0, bus.tx_valid}, 32'd1);
        wait_idle(50);
        chk("spi_start_count", n_spi - c0, 1);

        // Image stream, 3 pixels
        c0 = n_img;
        push_pix(16'hFFFF); push_pix(16'hAAAA); push_pix(16'h0001);
        send(8'hA2); send(8'h03); send_end();
        wait_idle(200);
        chk("img3_rd_count", n_img - c0, 3);
        chk("img3_idle", {31'd0, bus.busy}, 32'd0);

        // Image stream, N=0 means 256
        c0 = n_img; t0 = n_tx;
        for (int i = 0; i < 256; i++) push_pix(16'($urandom));
        send(8'hA2); send(8'h00); send_end();
        wait_idle(5000);
        chk("img256_rd_count", n_img - c0, 256);
        chk("img256_bytes", n_tx - t0, 512);

        // Backpressure on a reply
        exp_spi_tx = 8'h77;
        exp_tx.push_back(8'h3C);
        bus.tx_ready = 1'b0;
        send(8'hA1); send(8'h77); send_end();
        spi_reply(5, 8'h3C);
        repeat (50) @(posedge clk);
        #1;
        chk("bp_valid", {31'd0, bus.tx_valid}, 32'd1);
        chk("bp_data", {24'd0, bus.tx_data}, 32'h3C);
        bus.tx_ready = 1'b1;
        wait_idle(50);

        // Byte dropped mid-stream
        e0 = n_err;
        push_pix(16'h1357); push_pix(16'h2468);
        send(8'hA2); send(8'h02); send_end();
        @(posedge clk);
        send(8'h99); send_end();
        wait_idle(200);
        chk("drop_err", n_err - e0, 1);

        // Unknown command
        e0 = n_err;
        exp_tx.push_back(8'hEE);
        send(8'h55); send_end();
        wait_idle(50);
        chk("unknown_err", n_err - e0, 1);

        // Silence after A0
        e0 = n_err;
        exp_tx.push_back(8'hEE);
        send(8'hA0); send_end();
        wait_idle(TIMEOUT + 50);
        chk("arg_timeout_err", n_err - e0, 1);

        // SPI never answers
        e0 = n_err; exp_spi_tx = 8'h11;
        exp_tx.push_back(8'hEE);
        send(8'hA1); send(8'h11); send_end();
        wait_idle(TIMEOUT + 50);
        chk("spi_timeout_err", n_err - e0, 1);

        // Reset while a pixel high byte is waiting
        bus.tx_ready = 1'b0;
        push_pix(16'h1234);
        send(8'hA2); send(8'h01); send_end();
        begin
            int k;
            for (k = 0; k < 50; k++) begin
                if (bus.tx_valid) break;
                @(posedge clk); #1;
            end
            if (k == 50) chk("img_hi_reach", 32'd0, 32'd1);
        end
        reset = 1'b1;
        #1;
        chk("rst_mid_tx_valid", {31'd0, bus.tx_valid}, 32'd0);
        chk("rst_mid_tx_data", {24'd0, bus.tx_data}, 32'd0);
        chk("rst_mid_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_mid_tg_addr", {24'd0, bus.tg_addr}, 32'd0);
        chk("rst_mid_spi_tx", {24'd0, bus.spi_tx}, 32'd0);
        chk("rst_mid_img_rd", {31'd0, bus.img_rd}, 32'd0);
        exp_tx.delete();
        src_pix.delete();
        bus.tx_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Normal command after reset
        exp_tg_addr = 8'h56; exp_tg_wdata = 8'h78; c0 = n_tg;
        exp_tx.push_back(8'hA0);
        send(8'hA0); send(8'h56); send(8'h78); send_end();
        wait_idle(50);
        chk("post_rst_tg_count", n_tg - c0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end
endmodule
